// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Entries carry the fetch PC alongside the returned word.
package fetch_ctrl_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FAULT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   // Redirect targets are always forced onto a word boundary.
   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_ctrl_buf.sv
// Small circular FIFO of fetch entries with a registered head and flush.
// Slot storage is reset to zero so the head reads zero out of reset.
module fetch_buf
   import fetch_ctrl_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  logic         pop,
   input  fetch_entry_t push_entry,
   output fetch_entry_t head_entry,
   output logic         full,
   output logic         empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;

   logic [AW-1:0] wr_ptr_reg;
   logic [AW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          push_ok;
   logic          pop_ok;
   fetch_entry_t  slot_w [DEPTH];

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == CW'(DEPTH));
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_slot
         fetch_entry_t slot_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               slot_reg <= '0;
            end else if (push_ok && !flush && wr_ptr_reg == AW'(gi)) begin
               slot_reg <= push_entry;
            end
         end
         assign slot_w[gi] = slot_reg;
      end
   endgenerate

   assign head_entry = slot_w[rd_ptr_reg];

   // Flush wins over any same-cycle push or pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= (wr_ptr_reg == AW'(DEPTH - 1)) ? '0 : wr_ptr_reg + AW'(1);
         end
         if (pop_ok) begin
            rd_ptr_reg <= (rd_ptr_reg == AW'(DEPTH - 1)) ? '0 : rd_ptr_reg + AW'(1);
         end
         count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, fetches from a combinational instruction
// memory into a prefetch buffer, and hands instructions to decode.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    MEM_SIZE   = 1024,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
   parameter int                    BUF_DEPTH  = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fetch_en_i,
   output logic [DATA_WIDTH-1:0] imem_addr_o,
   input  logic [DATA_WIDTH-1:0] imem_instr_i,
   input  logic                  redirect_i,
   input  logic [DATA_WIDTH-1:0] redirect_pc_i,
   output logic                  instr_valid_o,
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic [DATA_WIDTH-1:0] pc_o,
   input  logic                  instr_ready_i,
   output logic                  fetch_fault_o,
   output logic [31:0]           fetch_count_o
);

   localparam logic [DATA_WIDTH-1:0] FETCH_LIMIT = DATA_WIDTH'(MEM_SIZE * INSTR_BYTES);

   fetch_state_e          state_reg, state_next;
   logic [DATA_WIDTH-1:0] pc_reg, pc_next;
   logic [31:0]           count_reg;
   logic                  in_range;
   logic                  pop;
   logic                  push;
   logic                  buf_full;
   logic                  buf_empty;
   fetch_entry_t          push_entry;
   fetch_entry_t          head_entry;

   assign in_range      = (pc_reg < FETCH_LIMIT);
   assign instr_valid_o = ~buf_empty;
   assign pop           = instr_valid_o & instr_ready_i;
   assign push          = (state_reg == FETCH) & ~redirect_i & in_range & (~buf_full | pop);

   assign push_entry.pc    = pc_reg;
   assign push_entry.instr = imem_instr_i;

   fetch_buf #(
      .DEPTH (BUF_DEPTH)
   ) u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (redirect_i),
      .push       (push),
      .pop        (pop),
      .push_entry (push_entry),
      .head_entry (head_entry),
      .full       (buf_full),
      .empty      (buf_empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         pc_reg    <= RESET_PC;
         count_reg <= '0;
      end else begin
         state_reg <= state_next;
         pc_reg    <= pc_next;
         if (push) begin
            count_reg <= count_reg + 32'd1;
         end
      end
   end

   // A redirect overrides every state, including the sticky fault.
   always_comb begin
      state_next = state_reg;
      pc_next    = pc_reg;
      if (redirect_i) begin
         state_next = fetch_en_i ? FETCH : IDLE;
         pc_next    = align_word(redirect_pc_i);
      end else begin
         if (push) begin
            pc_next = pc_reg + DATA_WIDTH'(INSTR_BYTES);
         end
         case (state_reg)
            IDLE:    if (fetch_en_i) state_next = FETCH;
            FETCH: begin
               if (!in_range)        state_next = FAULT;
               else if (!fetch_en_i) state_next = IDLE;
            end
            FAULT:   state_next = FAULT;
            default: state_next = IDLE;
         endcase
      end
   end

   assign imem_addr_o   = pc_reg;
   assign instr_o       = head_entry.instr;
   assign pc_o          = head_entry.pc;
   assign fetch_fault_o = (state_reg == FAULT);
   assign fetch_count_o = count_reg;

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the core's combinational instruction memory. It owns the PC, drives the word-aligned fetch address, and captures each returned word into a 2-entry prefetch buffer. It presents instructions to decode over a valid/ready handshake, and handles redirects from branch/jump resolution. It sits between instr_mem and the decode stage.

Parameters:
DATA_WIDTH, 32, address and instruction width
MEM_SIZE, 1024, instruction memory depth in words; the fetch-range limit is MEM_SIZE*4 bytes
RESET_PC, 32'h0000_0000, PC loaded at reset; must be 4-byte aligned
BUF_DEPTH, 2, prefetch buffer entries; only 2 is supported

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
fetch_en_i  in  1  allow new fetches
imem_addr_o  out  DATA_WIDTH  byte address to instr_mem; always equals pc_q
imem_instr_i  in  DATA_WIDTH  instruction word; valid combinationally in the same cycle as imem_addr_o
redirect_i  in  1  flush and reload the PC
redirect_pc_i  in  DATA_WIDTH  redirect target; bits [1:0] are ignored (forced 0)
instr_valid_o  out  1  buffer head is valid
instr_o  out  DATA_WIDTH  head instruction
pc_o  out  DATA_WIDTH  PC of the head instruction
instr_ready_i  in  1  decode accepts the head
fetch_fault_o  out  1  sticky flag: PC left the memory range
fetch_count_o  out  32  count of instructions pushed into the buffer; wraps

Behaviour:
- Reset (async assert, sync release):
  - pc_q=RESET_PC, state=IDLE, buffer empty.
  - instr_valid_o=0, instr_o=0, pc_o=0, fetch_fault_o=0, fetch_count_o=0.
- States:
  - IDLE: no fetch. Moves to FETCH in the cycle after fetch_en_i=1.
  - FETCH: fetching. Moves to IDLE in the cycle after fetch_en_i=0. The buffer keeps draining while in IDLE.
  - FAULT: entered when pc_q >= MEM_SIZE*4 while in FETCH. No pushes. fetch_fault_o=1.
  - FAULT exits only on redirect_i, then goes to FETCH if fetch_en_i=1, else IDLE.
- pop = instr_valid_o & instr_ready_i.
- push = (state==FETCH) & ~redirect_i & (pc_q < MEM_SIZE*4) & (count<2 | pop).
- On push:
  - Enqueue {pc_q, imem_instr_i}.
  - pc_q <= pc_q+4; wraps modulo 2^32.
  - fetch_count_o increments.
- Latency: the first instruction is visible one cycle after push, i.e. 2 cycles after fetch_en_i rises from reset.
- Throughput: 1 instr/cycle while decode stays ready.
- Buffer:
  - 2-entry circular FIFO; head is registered.
  - Full: push only if pop occurs in the same cycle.
  - Empty: instr_valid_o=0; instr_o and pc_o hold their last values (don't-care).
  - Simultaneous push and pop on a full buffer: count is unchanged, order is preserved.
- Redirect:
  - Has highest priority over push and pop.
  - Same cycle: no push; a pop that coincides with it is still counted as accepted by decode.
  - Next cycle: buffer empty, instr_valid_o=0, pc_q={redirect_pc_i[31:2],2'b00}, fetch_fault_o=0.
  - Fetching resumes from the new PC in that cycle if state is FETCH.
- Back-to-back redirects: the last target wins; nothing is pushed between them.
- fetch_en_i deasserted: the current cycle's push still occurs if legal; buffered entries remain and drain normally.
- Reset mid-operation: immediately returns to the reset values; in-flight buffer contents are discarded.
- instr_valid_o must not drop without a pop or redirect. instr_o and pc_o are stable while instr_valid_o=1 and instr_ready_i=0.

Decomposition:
- Shared core package holds:
  - fetch_state_e (IDLE, FETCH, FAULT).
  - fetch_entry_t struct {pc, instr}.
  - Constant INSTR_BYTES=4.
- One natural sub-module, fetch_buf: a 2-entry FIFO of fetch_entry_t with push/pop/flush and full/empty flags.
- FSM and PC logic stay in fetch_ctrl.

Test Plan:
- Reset, fetch_en_i=1, ready=1, memory holds 0x00100093 at word 0 and 0x00200113 at word 1 -> the next two consecutive cycles give valid instr/pc pairs 0x00100093/0x0 then 0x00200113/0x4; fetch_count_o increments each cycle.
- Backpressure: ready=0 for 5 cycles -> buffer holds PC 0x0 and 0x4; pc_q stays 0x8; head is stable. Raise ready -> 0x0, 0x4, 0x8 in order, with no loss or duplication.
- Redirect to 0x1E while the buffer is full and ready=1 -> next cycle valid=0; first post-redirect instr has pc_o=0x1C; flushed entries never appear.
- Run off the end with MEM_SIZE=4 -> after PC 0xC is pushed, fetch_fault_o=1 and no further pushes. Redirect to 0x0 -> fault clears and fetch restarts at 0x0.
- fetch_en_i dropped with 2 buffered entries -> both drain, then valid=0 and pc_q is frozen. Re-enable -> fetching resumes at the frozen PC.
- Assert rst_n low mid-stream with the buffer full -> outputs clear asynchronously. After release, pc_o of the first instr equals RESET_PC.
